dmem_port_arbiter: RTL

//  Shares the single-port data memory in the MEM stage between two requesters:

---
 rtl/dmem_arb_pkg.sv | 23 ++
 rtl/dmem_port_arbiter_if.sv | 22 ++
 rtl/dmem_arb_starve_ctr.sv | 38 +++
 rtl/dmem_port_arbiter.sv | 139 +++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the data-memory port arbiter.
// Revision 1.0
`default_nettype none

package dmem_arb_pkg;

  typedef enum logic [0:0] {
    ARB_NORMAL = 1'b0,
    ARB_FORCE  = 1'b1
  } arb_state_e;

  typedef enum logic [0:0] {
    SEL_P0 = 1'b0,
    SEL_P1 = 1'b1
  } port_sel_e;

  localparam int DMEM_STARVE_LIMIT = 4;
  // Wide enough for the largest legal limit (15).
  localparam int STARVE_CNT_W      = 4;

endpackage

`default_nettype wire

// File: rtl/dmem_port_arbiter_if.sv
// dmem_port_if: one requester port of the data-memory arbiter (request, write data, grant, read response).
// Revision 1.0
`default_nettype none

interface dmem_port_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              stall;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, stall, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, stall, rvalid, rdata);
endinterface

`default_nettype wire

// File: rtl/dmem_arb_starve_ctr.sv
// dmem_arb_starve_ctr: counts consecutive port-1 denials and requests a forced grant at STARVE_LIMIT.
// Revision 1.0
`default_nettype none

module dmem_arb_starve_ctr
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = DMEM_STARVE_LIMIT
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic p0_req,
  input  wire logic p1_req,
  input  wire logic in_normal,
  output logic      force_req
);
  localparam logic [STARVE_CNT_W-1:0] LIMIT_M1 = STARVE_CNT_W'(STARVE_LIMIT - 1);

  logic [STARVE_CNT_W-1:0] starve_cnt;
  logic                    deny;

  // In normal arbitration port 1 loses exactly when port 0 also asks.
  assign deny      = in_normal & p1_req & p0_req;
  assign force_req = deny & (starve_cnt == LIMIT_M1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (deny) begin
      starve_cnt <= starve_cnt + 1'b1;
    end else begin
      starve_cnt <= '0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: fixed-priority (port 0) data-memory arbiter with port-1 starvation guard.
// Optional saturating perf counters built when DMEM_ARB_PERF_EN is defined. Revision 1.0
`default_nettype none

module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = DMEM_STARVE_LIMIT,
  parameter int PERF_CNT_W   = 16
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  dmem_port_if.slave                 p0,
  dmem_port_if.slave                 p1,
  output logic      [ADDR_W-1:0]     mem_addr,
  output logic      [DATA_W-1:0]     mem_wdata,
  output logic                       mem_we,
  input  wire logic [DATA_W-1:0]     mem_rdata,
  output logic      [PERF_CNT_W-1:0] perf_p1_grants,
  output logic      [PERF_CNT_W-1:0] perf_conflicts
);
  arb_state_e        state;
  arb_state_e        state_nxt;
  port_sel_e         sel;
  logic              gnt0;
  logic              gnt1;
  logic              force_req;
  logic              rvalid0;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;

  dmem_arb_starve_ctr #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .p0_req   (p0.req),
    .p1_req   (p1.req),
    .in_normal(state == ARB_NORMAL),
    .force_req(force_req)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ARB_NORMAL;
    end else begin
      state <= state_nxt;
    end
  end

  // Grants are suppressed while reset is held so no write can slip out.
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    state_nxt = state;
    if (rst) begin
      case (state)
        ARB_NORMAL: begin
          if (p0.req) begin
            gnt0 = 1'b1;
          end else if (p1.req) begin
            gnt1 = 1'b1;
          end
          if (force_req) begin
            state_nxt = ARB_FORCE;
          end
        end
        ARB_FORCE: begin
          state_nxt = ARB_NORMAL;
          if (p1.req) begin
            gnt1 = 1'b1;
          end else if (p0.req) begin
            gnt0 = 1'b1;
          end
        end
        default: state_nxt = ARB_NORMAL;
      endcase
    end
  end

  assign sel       = gnt1 ? SEL_P1 : SEL_P0;
  assign mem_addr  = (sel == SEL_P1) ? p1.addr  : p0.addr;
  assign mem_wdata = (sel == SEL_P1) ? p1.wdata : p0.wdata;
  assign mem_we    = (gnt0 & p0.we) | (gnt1 & p1.we);

  assign p0.gnt   = gnt0;
  assign p1.gnt   = gnt1;
  assign p0.stall = p0.req & ~gnt0;
  assign p1.stall = p1.req & ~gnt1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= gnt0 & ~p0.we;
      rvalid1 <= gnt1 & ~p1.we;
      if (gnt0 & ~p0.we) begin
        rdata0 <= mem_rdata;
      end
      if (gnt1 & ~p1.we) begin
        rdata1 <= mem_rdata;
      end
    end
  end

  // A response still in flight when reset arrives is dropped immediately.
  assign p0.rvalid = rvalid0 & rst;
  assign p1.rvalid = rvalid1 & rst;
  assign p0.rdata  = rdata0;
  assign p1.rdata  = rdata1;

`ifdef DMEM_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_p1_grants <= '0;
      perf_conflicts <= '0;
    end else begin
      if (gnt1 && (perf_p1_grants != '1)) begin
        perf_p1_grants <= perf_p1_grants + 1'b1;
      end
      if (p0.req && p1.req && (perf_conflicts != '1)) begin
        perf_conflicts <= perf_conflicts + 1'b1;
      end
    end
  end
`else
  assign perf_p1_grants = '0;
  assign perf_conflicts = '0;
`endif

endmodule

`default_nettype wire
